// File: rtl/udt_pkg.sv
// Shared UDT definitions for the inbound classifier: control types, sink one-hot codes,
// FSM states and the header decode used to pick a sink or drop a packet.
package udt_pkg;

  localparam logic [14:0] CT_HS        = 15'h0000;
  localparam logic [14:0] CT_KEEPALIVE = 15'h0001;
  localparam logic [14:0] CT_ACK       = 15'h0002;
  localparam logic [14:0] CT_NAK       = 15'h0003;
  localparam logic [14:0] CT_CWARN     = 15'h0004;
  localparam logic [14:0] CT_SHUTDOWN  = 15'h0005;
  localparam logic [14:0] CT_ACK2      = 15'h0006;
  localparam logic [14:0] CT_MSGDROP   = 15'h0007;
  localparam logic [14:0] CT_USER      = 15'h7FFF;

  localparam int HDR_F_BIT  = 63;
  localparam int HDR_CT_MSB = 62;
  localparam int HDR_CT_LSB = 48;

  localparam logic [3:0] SEL_HS    = 4'b0001;
  localparam logic [3:0] SEL_CLOSE = 4'b0010;
  localparam logic [3:0] SEL_CTRL  = 4'b0100;
  localparam logic [3:0] SEL_DATA  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_EMIT0 = 3'd2,
    S_EMIT1 = 3'd3,
    S_FWD   = 3'd4,
    S_DROP  = 3'd5
  } state_t;

  typedef struct packed {
    logic       drop;
    logic [3:0] sel;
  } decode_t;

  // w0_hi is hdr0[63:48] (F flag + control type); dest is beat1[31:0].
  function automatic decode_t hdr_decode(input logic [15:0] w0_hi,
                                         input logic [31:0] dest,
                                         input logic [31:0] sock_id);
    decode_t    d;
    logic [14:0] ct;
    ct     = w0_hi[14:0];
    d.drop = 1'b0;
    d.sel  = SEL_DATA;
    if (w0_hi[15]) begin
      case (ct)
        CT_HS:       d.sel = SEL_HS;
        CT_SHUTDOWN: d.sel = SEL_CLOSE;
        CT_KEEPALIVE, CT_ACK, CT_NAK, CT_CWARN,
        CT_ACK2, CT_MSGDROP, CT_USER: d.sel = SEL_CTRL;
        default: begin
          d.drop = 1'b1;
          d.sel  = 4'b0000;
        end
      endcase
    end else begin
      d.sel = SEL_DATA;
    end
    if ((sock_id != 32'h0000_0000) && (dest != sock_id)) begin
      d.drop = 1'b1;
    end else begin
      d.drop = d.drop;
    end
    return d;
  endfunction

endpackage

// File: rtl/udt_rx_classifier.sv
// Inbound UDT classifier: buffers the two header beats, filters on destination socket ID
// and routes the packet to the handshake, shutdown, control or data sink.
module udt_rx_classifier
  import udt_pkg::*;
#(
  parameter logic [31:0] SOCK_ID    = 32'h0000_0000,
  parameter int          DROP_CNT_W = 16
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic [63:0]           s_tdata_i,
  input  logic [7:0]            s_tkeep_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  output logic [63:0]           m_tdata_o,
  output logic [7:0]            m_tkeep_o,
  output logic                  m_tlast_o,
  output logic                  hs_tvalid_o,
  input  logic                  hs_tready_i,
  output logic                  close_tvalid_o,
  input  logic                  close_tready_i,
  output logic                  ctrl_tvalid_o,
  input  logic                  ctrl_tready_i,
  output logic                  data_tvalid_o,
  input  logic                  data_tready_i,
  output logic                  rsp_pulse_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam logic [DROP_CNT_W-1:0] CNT_MAX = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] CNT_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  state_t                state_r, state_s;
  logic [63:0]           hdr0_r, hdr1_r;
  logic [7:0]            keep1_r;
  logic                  last1_r, keep0_bad_r, rsp_r, run_r;
  logic [3:0]            sel_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  decode_t               dec_s;
  logic                  valid_s, sel_ready_s, in_acc_s, drop_inc_s, accept_s;

  assign in_acc_s    = s_tvalid_i & s_tready_o;
  assign sel_ready_s = |(sel_r & {data_tready_i, ctrl_tready_i, close_tready_i, hs_tready_i});

  assign hs_tvalid_o    = sel_r[0] & valid_s;
  assign close_tvalid_o = sel_r[1] & valid_s;
  assign ctrl_tvalid_o  = sel_r[2] & valid_s;
  assign data_tvalid_o  = sel_r[3] & valid_s;
  assign rsp_pulse_o    = rsp_r;
  assign drop_cnt_o     = drop_cnt_r;

  // Next-state, input ready and shared output mux.
  always_comb begin
    state_s    = state_r;
    s_tready_o = 1'b0;
    valid_s    = 1'b0;
    m_tdata_o  = 64'h0;
    m_tkeep_o  = 8'h00;
    m_tlast_o  = 1'b0;
    drop_inc_s = 1'b0;
    accept_s   = 1'b0;
    dec_s      = hdr_decode(hdr0_r[HDR_F_BIT:HDR_CT_LSB], s_tdata_i[31:0], SOCK_ID);
    case (state_r)
      S_IDLE: begin
        // run_r keeps ready low for the first cycle out of reset
        s_tready_o = run_r;
        if (run_r && s_tvalid_i) begin
          if (s_tlast_i) begin
            drop_inc_s = 1'b1;
          end else begin
            state_s = S_HDR;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        s_tready_o = 1'b1;
        if (s_tvalid_i) begin
          if (dec_s.drop || keep0_bad_r) begin
            drop_inc_s = 1'b1;
            state_s    = s_tlast_i ? S_IDLE : S_DROP;
          end else begin
            accept_s = 1'b1;
            state_s  = S_EMIT0;
          end
        end else begin
          state_s = S_HDR;
        end
      end
      S_EMIT0: begin
        valid_s   = 1'b1;
        m_tdata_o = hdr0_r;
        m_tkeep_o = 8'hFF;
        state_s   = sel_ready_s ? S_EMIT1 : S_EMIT0;
      end
      S_EMIT1: begin
        valid_s   = 1'b1;
        m_tdata_o = hdr1_r;
        m_tkeep_o = keep1_r;
        m_tlast_o = last1_r;
        if (sel_ready_s) begin
          state_s = last1_r ? S_IDLE : S_FWD;
        end else begin
          state_s = S_EMIT1;
        end
      end
      S_FWD: begin
        valid_s    = s_tvalid_i;
        m_tdata_o  = s_tdata_i;
        m_tkeep_o  = s_tkeep_i;
        m_tlast_o  = s_tlast_i;
        s_tready_o = sel_ready_s;
        state_s    = (s_tvalid_i && sel_ready_s && s_tlast_i) ? S_IDLE : S_FWD;
      end
      S_DROP: begin
        s_tready_o = 1'b1;
        state_s    = (s_tvalid_i && s_tlast_i) ? S_IDLE : S_DROP;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, header buffer, sink select and counters.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_r     <= S_IDLE;
      run_r       <= 1'b0;
      hdr0_r      <= 64'h0;
      hdr1_r      <= 64'h0;
      keep1_r     <= 8'h00;
      last1_r     <= 1'b0;
      keep0_bad_r <= 1'b0;
      sel_r       <= 4'b0000;
      rsp_r       <= 1'b0;
      drop_cnt_r  <= {DROP_CNT_W{1'b0}};
    end else begin
      run_r   <= 1'b1;
      state_r <= state_s;
      rsp_r   <= accept_s;
      if ((state_r == S_IDLE) && in_acc_s) begin
        hdr0_r      <= s_tdata_i;
        keep0_bad_r <= (s_tkeep_i != 8'hFF);
      end
      if ((state_r == S_HDR) && in_acc_s) begin
        hdr1_r  <= s_tdata_i;
        keep1_r <= s_tkeep_i;
        last1_r <= s_tlast_i;
      end
      if (accept_s) begin
        sel_r <= dec_s.sel;
      end
      if (drop_inc_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
    end
  end

endmodule
